// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing generator.
//   - mode_e       : output colour mode encoding
//   - DEF_*        : default 640x480 @ 60 Hz timing (pixels / lines)
//   - total_len()  : sum of the four region lengths of one axis
//   - bar_index()  : colour-bar number (0..7) of a horizontal position
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,   // colour from the external pixel source
        MODE_BARS  = 2'b01,   // eight vertical colour bars
        MODE_WHITE = 2'b10,
        MODE_BLACK = 2'b11
    } mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int total_len(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Bar b satisfies b = floor(x*8 / h_active). Built as a threshold
    // compare chain so only constant multiplies appear in hardware.
    function automatic logic [2:0] bar_index(input int x, input int h_active);
        logic [2:0] idx;
        idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (x * 8 >= k * h_active) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// vga_pipe_delay: DEPTH-stage shift register that advances only when en=1.
// DEPTH=0 is a plain wire.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (stages clear to 0)
//   en         : advance enable (pixel tick)
//   d / q      : W-bit input / DEPTH-ticks-delayed output
module vga_pipe_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with selectable test patterns.
// Ports:
//   clk_100MHz, rst_n      : clock, asynchronous active-low reset
//   mode                   : colour mode (mode_e), taken at frame start
//   pix_r/g/b              : colour from a source registered PIPE ticks
//                            after it saw pix_x/pix_y
//   pix_ce                 : one-clk pixel tick
//   pix_x, pix_y, pix_req  : coordinate requested from the source, and
//                            whether it lies in the active area
//   vga_r/g/b, Hsync_s/Vsync_s : registered connector outputs
//   frame_start, line_start    : one-clk markers on the tick at x=0
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int PIPE     = 1,
    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic               clk_100MHz,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               pix_ce,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               pix_req,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               Hsync_s,
    output logic               Vsync_s,
    output logic               frame_start,
    output logic               line_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    // One extra bit so region ends equal to the total never truncate.
    localparam logic [XW:0] H_ACT_END  = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] H_SYNC_BEG = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] H_SYNC_END = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0] V_ACT_END  = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] V_SYNC_BEG = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] V_SYNC_END = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam int DLW = XW + 3;

    logic [DW-1:0]      div_cnt;
    logic [XW-1:0]      h_cnt;
    logic [YW-1:0]      v_cnt;
    logic               in_active;
    logic               raw_hs;
    logic               raw_vs;
    logic [DLW-1:0]     dl_in;
    logic [DLW-1:0]     dl_out;
    logic               d_hs;
    logic               d_vs;
    logic               d_act;
    logic [XW-1:0]      d_x;
    mode_e              mode_q;
    logic [2:0]         bar;
    logic [COLOR_W-1:0] col_r;
    logic [COLOR_W-1:0] col_g;
    logic [COLOR_W-1:0] col_b;

    // pix_ce is registered so it is 0 in reset and first rises exactly
    // CLK_DIV clocks after release; with CLK_DIV=1 it then stays high.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pix_ce  <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            pix_ce  <= (div_cnt == DIV_LAST);
        end
    end

    // Counters step at the end of each tick cycle, so during a tick they
    // still show the coordinate being requested.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + YW'(1);
            end else begin
                h_cnt <= h_cnt + XW'(1);
            end
        end
    end

    assign in_active   = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
    assign raw_hs      = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
    assign raw_vs      = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    // Counters sit at 0,0 in reset, which would otherwise look active.
    assign pix_req     = rst_n & in_active;
    assign line_start  = pix_ce & (h_cnt == '0);
    assign frame_start = line_start & (v_cnt == '0);

    // Delay timing and x so they line up with the source colour.
    assign dl_in = {raw_hs, raw_vs, in_active, h_cnt};

    vga_pipe_delay #(
        .DEPTH (PIPE),
        .W     (DLW)
    ) u_delay (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .en    (pix_ce),
        .d     (dl_in),
        .q     (dl_out)
    );

    assign {d_hs, d_vs, d_act, d_x} = dl_out;

    // Mode only changes on a frame boundary so a frame is never mixed.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n)           mode_q <= MODE_PASS;
        else if (frame_start) mode_q <= mode_e'(mode);
    end

    always_comb begin
        col_r = '0;
        col_g = '0;
        col_b = '0;
        bar   = bar_index(int'(d_x), H_ACTIVE);
        if (d_act) begin
            case (mode_q)
                MODE_PASS: begin
                    col_r = pix_r;
                    col_g = pix_g;
                    col_b = pix_b;
                end
                MODE_BARS: begin
                    col_r = {COLOR_W{bar[2]}};
                    col_g = {COLOR_W{bar[1]}};
                    col_b = {COLOR_W{bar[0]}};
                end
                MODE_WHITE: begin
                    col_r = '1;
                    col_g = '1;
                    col_b = '1;
                end
                MODE_BLACK: begin
                    col_r = '0;
                    col_g = '0;
                    col_b = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
            Hsync_s <= ~H_POL;
            Vsync_s <= ~V_POL;
        end else if (pix_ce) begin
            vga_r   <= col_r;
            vga_g   <= col_g;
            vga_b   <= col_b;
            Hsync_s <= d_hs ? H_POL : ~H_POL;
            Vsync_s <= d_vs ? V_POL : ~V_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-raster bench (15x8 total, 8x4 active, CLK_DIV=2,
// PIPE=1, active-low syncs). Outputs are predicted from the raster rules:
// after clock edge k since reset release, tick position is (k-1)/CLK_DIV and
// the connector shows the pixel PIPE+1 positions earlier.
module tb_vga_timing_gen;

    localparam int D     = 2;
    localparam int HA    = 8;
    localparam int HF    = 2;
    localparam int HS    = 3;
    localparam int HB    = 2;
    localparam int VA    = 4;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int PIPE  = 1;
    localparam int H_TOT = HA + HF + HS + HB;
    localparam int V_TOT = VA + VF + VS + VB;
    localparam int FRAME = H_TOT * V_TOT;

    // clock / reset / DUT
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] pix_r, pix_g, pix_b;
    logic       pix_ce, pix_req, frame_start, line_start;
    logic [3:0] pix_x;
    logic [2:0] pix_y;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       Hsync_s, Vsync_s;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV (D),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL   (1'b0), .V_POL(1'b0),
        .COLOR_W (4),
        .PIPE    (PIPE)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .pix_ce     (pix_ce),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_req    (pix_req),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .Hsync_s    (Hsync_s),
        .Vsync_s    (Vsync_s),
        .frame_start(frame_start),
        .line_start (line_start)
    );

    // model state
    int         total = 0;
    int         bad   = 0;
    int         k;                       // clock edges since reset release
    logic       ce_prev;
    logic [3:0] x_prev, g_next, b_next;
    logic [1:0] frame_mode [0:63];       // mode taken at each frame start
    logic [3:0] exp_g [0:4095];          // source green/blue per tick
    logic [3:0] exp_b [0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    function automatic int hpos(input int p);
        return p % H_TOT;
    endfunction

    function automatic int vpos(input int p);
        return (p / H_TOT) % V_TOT;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_pix_ce"},      pix_ce,      0);
        chk({tag, "_pix_x"},       pix_x,       0);
        chk({tag, "_pix_y"},       pix_y,       0);
        chk({tag, "_pix_req"},     pix_req,     0);
        chk({tag, "_line_start"},  line_start,  0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_vga_r"},       vga_r,       0);
        chk({tag, "_vga_g"},       vga_g,       0);
        chk({tag, "_vga_b"},       vga_b,       0);
        chk({tag, "_hsync"},       Hsync_s,     1);
        chk({tag, "_vsync"},       Vsync_s,     1);
    endtask

    task automatic check_all();
        int pos, h, v, q, qh, qv, bar, er, eg, eb, ehs, evs;
        bit ce;
        pos = (k - 1) / D;
        ce  = (k % D) == 0;
        h   = hpos(pos);
        v   = vpos(pos);
        chk("pix_ce",      pix_ce,      ce);
        chk("pix_x",       pix_x,       h);
        chk("pix_y",       pix_y,       v);
        chk("pix_req",     pix_req,     (h < HA && v < VA));
        chk("line_start",  line_start,  (ce && h == 0));
        chk("frame_start", frame_start, (ce && h == 0 && v == 0));
        q   = pos - (PIPE + 1);
        er  = 0; eg = 0; eb = 0; ehs = 1; evs = 1;
        if (q >= 0) begin
            qh = hpos(q);
            qv = vpos(q);
            if (qh >= HA + HF && qh < HA + HF + HS) ehs = 0;
            if (qv >= VA + VF && qv < VA + VF + VS) evs = 0;
            if (qh < HA && qv < VA) begin
                case (frame_mode[q / FRAME])
                    2'd0: begin er = qh; eg = exp_g[q]; eb = exp_b[q]; end
                    2'd1: begin
                        bar = (qh * 8) / HA;
                        er  = (bar & 4) ? 15 : 0;
                        eg  = (bar & 2) ? 15 : 0;
                        eb  = (bar & 1) ? 15 : 0;
                    end
                    2'd2: begin er = 15; eg = 15; eb = 15; end
                    default: begin er = 0; eg = 0; eb = 0; end
                endcase
            end
        end
        chk("vga_r", vga_r,   er);
        chk("vga_g", vga_g,   eg);
        chk("vga_b", vga_b,   eb);
        chk("hsync", Hsync_s, ehs);
        chk("vsync", Vsync_s, evs);
    endtask

    // One clock: advance, emulate the registered pixel source, check.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if (ce_prev) begin
            pix_r = x_prev;
            pix_g = g_next;
            pix_b = b_next;
        end
        check_all();
        ce_prev = pix_ce;
        x_prev  = pix_x;
    endtask

    // Mode changes and source data for the tick ending at the next edge.
    task automatic drive(input int epoch);
        int pos;
        bit ce;
        pos = (k - 1) / D;
        ce  = (k % D) == 0;
        if (ce) begin
            if (epoch == 0 && pos == 60)              mode = 2'b01;
            if (epoch == 0 && pos == FRAME + 30)      mode = 2'b10;
            if (epoch == 0 && pos == 2 * FRAME + 50)  mode = 2'b11;
            if (epoch == 0 && pos == 6 * FRAME - 20)  mode = 2'b10;
            if ((epoch == 0 && pos >= 4 * FRAME && pos < 5 * FRAME) ||
                (epoch == 1 && pos >= FRAME)) begin
                if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
            end
            if (pos % FRAME == 0) frame_mode[pos / FRAME] = mode;
            g_next     = 4'($urandom_range(0, 15));
            b_next     = 4'($urandom_range(0, 15));
            exp_g[pos] = g_next;
            exp_b[pos] = b_next;
        end
    endtask

    initial begin
        int  tries;
        bit  found;
        rst_n   = 1'b0;
        mode    = 2'b00;
        pix_r   = '0;
        pix_g   = '0;
        pix_b   = '0;
        k       = 0;
        ce_prev = 1'b0;
        x_prev  = '0;
        g_next  = '0;
        b_next  = '0;

        // held in reset
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst_hold");

        // epoch 0: six frames with directed pass/bars/white/black frames
        rst_n = 1'b1;
        for (int i = 0; i < 6 * FRAME * D; i++) begin
            step();
            drive(0);
        end

        // run into the active area of frame 6 (line 2, pixel 3)
        found = 1'b0;
        tries = 0;
        while (!found && tries < FRAME * D) begin
            step();
            drive(0);
            tries++;
            if ((k % D) == 0 && ((k - 1) / D) % FRAME == 2 * H_TOT + 3) found = 1'b1;
        end
        chk("reach_active", found, 1);

        // asynchronous reset mid-line takes effect within the cycle
        rst_n = 1'b0;
        #2;
        reset_checks("rst_mid");
        repeat (3) begin
            @(posedge clk);
            #1;
            reset_checks("rst_mid_hold");
        end

        // epoch 1: restart from 0,0 with random mode changes
        k       = 0;
        ce_prev = 1'b0;
        mode    = 2'b00;
        rst_n   = 1'b1;
        for (int i = 0; i < 3 * FRAME * D; i++) begin
            step();
            drive(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
